// File: rtl/alu_exec.sv
// ============================================================================
// Module   : alu_exec
// Function : 32-bit ALU with valid/ready handshake; shifts are iterative
//            (one bit per cycle) unless ALU_EXEC_FAST_SHIFT_EN is defined,
//            which selects a single-cycle barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_control,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_alu_res;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_illegal;

`ifndef ALU_EXEC_FAST_SHIFT_EN
  logic [4:0]  r_cnt;
  logic [31:0] r_work;
  logic [3:0]  r_op;
  logic        w_is_shift;
  logic        w_start_shift;
  logic [31:0] w_shift1;
`endif

  assign w_accept = in_valid & (r_state == ST_IDLE);
  assign w_legal  = (alu_control <= OP_SRA);

  // Single-cycle result for everything that completes on the accept edge.
  always_comb begin
    w_alu_res = 32'd0;
    case (alu_control)
      OP_ADD: w_alu_res = a + b;
      OP_SUB: w_alu_res = a - b;
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_XOR: w_alu_res = a ^ b;
      OP_SLT: w_alu_res = {31'd0, ($signed(a) < $signed(b))};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL: w_alu_res = a << b[4:0];
      OP_SRL: w_alu_res = a >> b[4:0];
      OP_SRA: w_alu_res = $unsigned($signed(a) >>> b[4:0]);
`else
      OP_SLL,
      OP_SRL,
      OP_SRA: w_alu_res = a;  // only reached with a zero shift amount
`endif
      default: w_alu_res = 32'd0;
    endcase
  end

`ifndef ALU_EXEC_FAST_SHIFT_EN
  assign w_is_shift    = (alu_control == OP_SLL) | (alu_control == OP_SRL) |
                         (alu_control == OP_SRA);
  assign w_start_shift = w_is_shift & (b[4:0] != 5'd0);

  always_comb begin
    w_shift1 = r_work;
    case (r_op)
      OP_SLL:  w_shift1 = {r_work[30:0], 1'b0};
      OP_SRL:  w_shift1 = {1'b0, r_work[31:1]};
      default: w_shift1 = {r_work[31], r_work[31:1]};
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
          w_next_state = ST_DONE;
`else
          w_next_state = w_start_shift ? ST_SHIFT : ST_DONE;
`endif
        end
      end
      ST_SHIFT: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
        w_next_state = ST_IDLE;
`else
        if (r_cnt == 5'd1) begin
          w_next_state = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: result/zero/illegal load only on completion, then hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result  <= 32'd0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
      r_cnt     <= 5'd0;
      r_work    <= 32'd0;
      r_op      <= 4'd0;
`endif
    end else begin
      if (w_accept) begin
        r_illegal <= ~w_legal;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        if (w_start_shift) begin
          r_work <= a;
          r_cnt  <= b[4:0];
          r_op   <= alu_control;
        end else begin
          r_result <= w_alu_res;
          r_zero   <= (w_alu_res == 32'd0);
        end
`else
        r_result <= w_alu_res;
        r_zero   <= (w_alu_res == 32'd0);
`endif
      end
`ifndef ALU_EXEC_FAST_SHIFT_EN
      else if (r_state == ST_SHIFT) begin
        r_work <= w_shift1;
        r_cnt  <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_result <= w_shift1;
          r_zero   <= (w_shift1 == 32'd0);
        end
      end
`endif
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module   : tb_alu_exec
// Function : Directed self-checking bench for alu_exec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_exec u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int shift_lat(input logic [31:0] bv);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 1;
`else
    return int'(bv[4:0]) + 1;
`endif
  endfunction

  // Drive a request (caller is at a negedge), return edges until out_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output bit rdy_seen);
    alu_control = op;
    a           = av;
    b           = bv;
    in_valid    = 1'b1;
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    issue(op, av, bv, lat, rdy_seen);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    check({tag, "_busy"}, {31'd0, rdy_seen}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  rdy_seen;
    bit  spurious;

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    a           = 32'd0;
    b           = 32'd0;
    alu_control = 4'd0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    // First request accepted on the first edge after reset release
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, lat, rdy_seen);
    check("add_ovf_lat", lat, 1);
    check("add_ovf_res", result, 32'h8000_0000);
    check("add_ovf_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    check("add_ovf_drop", {31'd0, out_valid}, 32'd0);

    run_op("sub_eq",  4'd1, 32'd5,          32'd5,          32'd0,          1'b0, 1);
    run_op("slt_neg", 4'd5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1);
    run_op("slt_pos", 4'd5, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1);
    run_op("and",     4'd2, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0, 1);
    run_op("or",      4'd3, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'hFFF0_FFFF,  1'b0, 1);
    run_op("xor",     4'd6, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'hFF00_EDCB,  1'b0, 1);
    run_op("illegal", 4'hF, 32'h1234_5678,  32'h1,          32'd0,          1'b1, 1);
    run_op("sub_wrap",4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1);
    run_op("sll3",    4'd4, 32'd1,          32'hFFFF_FFE3,  32'd8,          1'b0, shift_lat(32'hFFFF_FFE3));
    run_op("sll0",    4'd4, 32'hDEAD_BEEF,  32'h20,         32'hDEAD_BEEF,  1'b0, 1);
    run_op("sra4",    4'd8, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, shift_lat(32'd4));
    run_op("sra31",   4'd8, 32'h4000_0000,  32'd31,         32'd0,          1'b0, shift_lat(32'd31));

    // srl held under backpressure; a competing request in DONE is ignored
    out_ready = 1'b0;
    @(negedge clk);
    issue(4'd7, 32'h8000_0000, 32'h24, lat, rdy_seen);
    check("srl_lat", lat, shift_lat(32'h24));
    check("srl_busy", {31'd0, rdy_seen}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = 4'd0;
      a           = 32'd1;
      b           = 32'd1;
      @(posedge clk);
      #1;
      check("srl_hold_valid", {31'd0, out_valid}, 32'd1);
      check("srl_hold_res", result, 32'h0800_0000);
      check("srl_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("srl_release_valid", {31'd0, out_valid}, 32'd0);
    check("srl_release_rdy", {31'd0, in_ready}, 32'd1);
    check("srl_release_res", result, 32'h0800_0000);

    // Reset pulse in the middle of a long shift
    @(negedge clk);
    alu_control = 4'd4;
    a           = 32'h0000_0003;
    b           = 32'd20;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    check("midrst_no_valid", {31'd0, spurious}, 32'd0);
    check("midrst_res_kept", result, 32'd0);

    run_op("add_after", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The port list SHALL be:
- clk  input  1  rising-edge clock.
- reset_n  input  1  async active-low reset.
- in_valid  input  1  operand/opcode request valid.
- in_ready  output  1  block can accept a request.
- a  input  32  source operand A.
- b  input  32  source operand B; b[4:0] is the shift amount.
- alu_control  input  4  ALU op code from the ALU decoder.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  operation result.
- zero  output  1  high when result == 0.
- illegal  output  1  op code was not legal.

Function
REQ-003 alu_control encoding SHALL be:
- 0000 add
- 0001 sub
- 0010 and
- 0011 or
- 0100 sll
- 0101 slt (signed)
- 0110 xor
- 0111 srl
- 1000 sra
REQ-004 Any other alu_control value SHALL produce result=0, zero=1 and illegal=1.
REQ-005 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE.
REQ-007 A request SHALL be accepted when in_valid & in_ready; a, b and alu_control SHALL be captured on that edge.
REQ-008 Non-shift ops SHALL go IDLE->DONE with the result registered on the accept edge, so out_valid is high the cycle after acceptance (latency 1).
REQ-009 Shift ops with b[4:0]!=0 SHALL go IDLE->SHIFT and load a 5-bit counter with b[4:0].
- Each SHIFT cycle SHALL shift the working register by one bit (sll: zero fill left; srl: zero fill right; sra: replicate bit 31) and decrement the counter.
- The FSM SHALL move to DONE on the cycle the counter reaches 0.
- Latency SHALL be b[4:0]+1 cycles.
REQ-010 Shift ops with b[4:0]==0 SHALL go directly to DONE with result=a (latency 1).
REQ-011 In DONE, result, zero and illegal SHALL be held stable until out_valid & out_ready.
- On that handshake the FSM SHALL return to IDLE and drop out_valid in the next cycle.
REQ-012 In DONE, in_ready SHALL be 0; a simultaneous in_valid SHALL be ignored and not accepted.
REQ-013 Arithmetic SHALL be 32-bit modulo 2^32 with no carry or overflow output.
- slt SHALL return 32'h1 or 32'h0.
- Only b[4:0] SHALL be used for shifts; b[31:5] SHALL be ignored.
REQ-014 zero SHALL equal (result==0) and SHALL update only when result is loaded.
REQ-015 Inputs changing while the FSM is not in IDLE SHALL NOT affect an operation in flight.

Reset
REQ-016 Asserting reset_n low SHALL immediately force:
- state=IDLE, in_ready=1, out_valid=0
- result=0, zero=1, illegal=0, counter=0
REQ-017 Reset asserted during SHIFT or DONE SHALL abort the operation; no partial result SHALL be presented after reset is released.
REQ-018 The first request SHALL be accepted on the first rising edge after reset_n deasserts with in_valid high.

Configuration
REQ-019 When macro ALU_EXEC_FAST_SHIFT_EN is defined:
- shifts SHALL use a single-cycle barrel shifter;
- all legal ops SHALL go IDLE->DONE with latency 1;
- the SHIFT state and counter SHALL NOT be used.
REQ-020 When ALU_EXEC_FAST_SHIFT_EN is undefined, shifts SHALL be iterative per REQ-009/REQ-010.
REQ-021 Results SHALL be identical in both configurations; only latency differs.

Verification
REQ-022 add a=32'h7FFFFFFF, b=1, out_ready=1 -> out_valid one cycle after accept, result=32'h80000000, zero=0.
REQ-023 sub a=5, b=5 -> result=0, zero=1; slt a=32'hFFFFFFFF, b=1 -> result=1.
REQ-024 sra a=32'h80000000, b=4, iterative build:
- out_valid 5 cycles after accept, result=32'hF8000000;
- in_ready=0 throughout the operation.
REQ-025 srl a=32'h80000000, b=32'h24 (shamt 4) with out_ready=0 for 3 cycles -> result=32'h08000000 held stable until out_ready=1, then IDLE next cycle.
REQ-026 alu_control=4'b1111 -> illegal=1, result=0, zero=1 after 1 cycle.
REQ-027 reset_n pulsed low mid-SHIFT (sll, b=20) -> outputs at reset values immediately, no out_valid afterward until a new request is accepted.
